dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter IO_REGION, default 4'h1: value of addr[15:12] that marks the keyboard I/O window, which is read-only.
REQ-002 Parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority with m0 highest.
REQ-003 clk  in  1  single system clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset; synchronous, active-low.
REQ-005 m0_req  in  1  CPU port access request; held until m0_ack.
REQ-006 m0_we  in  1  CPU port write enable; 0 = read.
REQ-007 m0_addr  in  32  CPU port byte address.
REQ-008 m0_wdata  in  32  CPU port write data.
REQ-009 m0_ack  out  1  CPU port one-cycle completion pulse.
REQ-010 m0_rdata  out  32  CPU port read data; valid while m0_ack=1.
REQ-011 m1_req, m1_we, m1_addr[31:0], m1_wdata[31:0], m1_ack, m1_rdata[31:0]: DMA/display port, same directions and meanings as the m0 signals.
REQ-012 ram_cs  out  1  data-RAM chip select.
REQ-013 ram_r  out  1  data-RAM read enable.
REQ-014 ram_we  out  1  data-RAM write enable.
REQ-015 ram_addr  out  32  data-RAM address.
REQ-016 ram_wdata  out  32  data-RAM write data.
REQ-017 ram_rdata  in  32  data-RAM combinational read data, including the keyboard word in the I/O window.

Function
REQ-018 The arbiter SHALL implement a three-state machine with states IDLE, ACCESS and DONE.
REQ-019 IDLE: if any req is high, the arbiter SHALL latch the granted master's index, we, addr and wdata, then go to ACCESS; if no req is high, it SHALL stay in IDLE.
REQ-020 ACCESS: for exactly one cycle the arbiter SHALL drive ram_cs=1, ram_r=~we, ram_we=we, and ram_addr/ram_wdata from the latched values; the RAM write commits at the closing edge; ram_rdata SHALL be registered at that same edge; next state is DONE.
REQ-021 DONE: the arbiter SHALL assert the granted master's ack for exactly one cycle, present the registered rdata on that master's rdata output, and return to IDLE.
REQ-022 Latency: req sampled high in IDLE at cycle N -> ack in cycle N+2. Maximum throughput is one access every 3 cycles.
REQ-023 A requester SHALL drop req, or change its request fields, only in the cycle after its ack; the arbiter SHALL ignore req from the acked master while in DONE.
REQ-024 Simultaneous m0_req and m1_req in IDLE with RR_EN=1: grant SHALL go to the master not granted last; after reset the last-granted pointer is m1, so m0 wins the first tie.
REQ-025 With RR_EN=0, m0 SHALL always win a tie.
REQ-026 A write whose latched addr[15:12] equals IO_REGION SHALL be suppressed (ram_we=0, ram_cs=1, ram_r=0) and SHALL still be acknowledged normally.
REQ-027 Outside ACCESS, all ram_* control outputs SHALL be 0; ram_addr and ram_wdata SHALL hold their last values.
REQ-028 rdata for a write access SHALL be 32'h0.
REQ-029 The latched request SHALL not change between IDLE and DONE, even if the req inputs change.
REQ-030 An idle master's rdata output SHALL hold its previous value; its ack SHALL be 0.

Reset
REQ-031 rst_n=0 at a clock edge SHALL force: state IDLE; all acks 0; ram_cs, ram_r, ram_we 0; ram_addr, ram_wdata, m0_rdata, m1_rdata 32'h0; last-granted pointer m1.
REQ-032 Reset asserted in ACCESS or DONE SHALL abort the access with no ack; a write issued in that ACCESS cycle is not guaranteed committed.

Structure
REQ-033 State encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2) and the IO_REGION default SHALL live in the shared dmem_pkg package.
REQ-034 Grant selection SHALL be one sub-module, rr_pick2: inputs req[1:0], last, rr_en; outputs gnt_idx, gnt_valid. All other logic is flat.

Verification
REQ-035 After reset, m0 reads 0x0000_0010 from a RAM holding 0xDEADBEEF at word 4 -> ram_cs=1, ram_r=1 in cycle N+1; m0_ack=1 and m0_rdata=0xDEADBEEF in N+2.
REQ-036 m1 writes 0x1234_5678 to 0x20, then reads 0x20 -> m1_rdata=0x12345678; ram_we was high for exactly one cycle.
REQ-037 m0_req and m1_req held high continuously with RR_EN=1 -> acks alternate m0, m1, m0, m1, one ack every 3 cycles; with RR_EN=0 -> m0 only while m0_req stays high.
REQ-038 m0 writes 0xFFFF_FFFF to 0x0000_1004 -> ram_we stays 0, m0_ack pulses in N+2; a read from 0x1004 returns the keyboard word.
REQ-039 rst_n driven low in the ACCESS cycle of an m1 read -> no m1_ack; the next cycle shows IDLE with all ram_* controls 0; a fresh m0 request is acked 2 cycles after it is sampled.
REQ-040 m1 changes m1_addr during ACCESS -> ram_addr keeps the originally latched address.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, the default
// keyboard I/O window and a small decode helper.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Value of addr[15:12] that selects the read-only keyboard window.
    localparam logic [3:0] IO_REGION_DEFAULT = 4'h1;

    // Read data returned to a master whose access was a write.
    localparam logic [31:0] RDATA_FOR_WRITE = 32'h0000_0000;

    // True when a write targets the read-only I/O window and must be dropped.
    function automatic logic is_io_write(
        input logic        we,
        input logic [31:0] addr,
        input logic [3:0]  region
    );
        return we && (addr[15:12] == region);
    endfunction

endpackage

// File: rtl/rr_pick2.sv
// Two-requester grant selection: round-robin against the last granted index
// when rr_en is set, otherwise fixed priority with requester 0 highest.
module rr_pick2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       rr_en,
    output logic       gnt_idx,
    output logic       gnt_valid
);

    // Pick the winner among the active requests.
    always_comb begin
        gnt_idx   = 1'b0;
        gnt_valid = 1'b0;
        case (req)
            2'b00: begin
                gnt_idx   = 1'b0;
                gnt_valid = 1'b0;
            end
            2'b01: begin
                gnt_idx   = 1'b0;
                gnt_valid = 1'b1;
            end
            2'b10: begin
                gnt_idx   = 1'b1;
                gnt_valid = 1'b1;
            end
            2'b11: begin
                gnt_valid = 1'b1;
                if (rr_en) begin
                    gnt_idx = ~last;
                end else begin
                    gnt_idx = 1'b0;
                end
            end
            default: begin
                gnt_idx   = 1'b0;
                gnt_valid = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: two masters (CPU on m0, DMA/display on m1) share one
// single-port data RAM. Each access runs IDLE -> ACCESS -> DONE, so a grant
// sampled in cycle N is acknowledged in cycle N+2. Writes into the keyboard
// I/O window are dropped but still acknowledged.
module dmem_arbiter
    import dmem_pkg::*;
#(
    parameter logic [3:0] IO_REGION = IO_REGION_DEFAULT,
    parameter bit         RR_EN     = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic        m0_ack,
    output logic [31:0] m0_rdata,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic        m1_ack,
    output logic [31:0] m1_rdata,
    output logic        ram_cs,
    output logic        ram_r,
    output logic        ram_we,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_wdata,
    input  logic [31:0] ram_rdata
);

    state_t      state_r;
    logic        gnt_idx_r;
    logic        we_r;
    logic        last_r;

    logic [1:0]  req_vec_s;
    logic        pick_idx_s;
    logic        pick_valid_s;
    logic        sel_we_s;
    logic [31:0] sel_addr_s;
    logic [31:0] sel_wdata_s;

    assign req_vec_s = {m1_req, m0_req};

    rr_pick2 u_pick (
        .req       (req_vec_s),
        .last      (last_r),
        .rr_en     (RR_EN),
        .gnt_idx   (pick_idx_s),
        .gnt_valid (pick_valid_s)
    );

    // Route the winning master's request fields toward the latch.
    always_comb begin
        sel_we_s    = 1'b0;
        sel_addr_s  = 32'h0000_0000;
        sel_wdata_s = 32'h0000_0000;
        if (pick_idx_s) begin
            sel_we_s    = m1_we;
            sel_addr_s  = m1_addr;
            sel_wdata_s = m1_wdata;
        end else begin
            sel_we_s    = m0_we;
            sel_addr_s  = m0_addr;
            sel_wdata_s = m0_wdata;
        end
    end

    // Access sequencer. ram_addr/ram_wdata double as the latched request
    // fields, so they naturally hold between accesses; ram_rdata is captured
    // straight into the granted master's rdata register at the end of ACCESS.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            gnt_idx_r <= 1'b0;
            we_r      <= 1'b0;
            last_r    <= 1'b1;
            ram_cs    <= 1'b0;
            ram_r     <= 1'b0;
            ram_we    <= 1'b0;
            ram_addr  <= 32'h0000_0000;
            ram_wdata <= 32'h0000_0000;
            m0_ack    <= 1'b0;
            m1_ack    <= 1'b0;
            m0_rdata  <= 32'h0000_0000;
            m1_rdata  <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    m0_ack <= 1'b0;
                    m1_ack <= 1'b0;
                    if (pick_valid_s) begin
                        gnt_idx_r <= pick_idx_s;
                        last_r    <= pick_idx_s;
                        we_r      <= sel_we_s;
                        ram_addr  <= sel_addr_s;
                        ram_wdata <= sel_wdata_s;
                        ram_cs    <= 1'b1;
                        ram_r     <= ~sel_we_s;
                        ram_we    <= sel_we_s & ~is_io_write(sel_we_s, sel_addr_s, IO_REGION);
                        state_r   <= ACCESS;
                    end else begin
                        ram_cs  <= 1'b0;
                        ram_r   <= 1'b0;
                        ram_we  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                ACCESS: begin
                    ram_cs <= 1'b0;
                    ram_r  <= 1'b0;
                    ram_we <= 1'b0;
                    if (gnt_idx_r) begin
                        m1_ack   <= 1'b1;
                        m1_rdata <= we_r ? RDATA_FOR_WRITE : ram_rdata;
                    end else begin
                        m0_ack   <= 1'b1;
                        m0_rdata <= we_r ? RDATA_FOR_WRITE : ram_rdata;
                    end
                    state_r <= DONE;
                end
                DONE: begin
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    ram_cs  <= 1'b0;
                    ram_r   <= 1'b0;
                    ram_we  <= 1'b0;
                    m0_ack  <= 1'b0;
                    m1_ack  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a round-robin instance drives a small RAM
// model, a fixed-priority instance shares the same master inputs.
module tb_dmem_arbiter;

    localparam logic [31:0] KBD_WORD = 32'h0000_004B;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        preload;
    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_ack, m1_ack;
    logic [31:0] m0_rdata, m1_rdata;
    logic        ram_cs, ram_r, ram_we;
    logic [31:0] ram_addr, ram_wdata, ram_rdata;

    logic        fp_m0_ack, fp_m1_ack;
    logic [31:0] fp_m0_rdata, fp_m1_rdata;
    logic        fp_ram_cs, fp_ram_r, fp_ram_we;
    logic [31:0] fp_ram_addr, fp_ram_wdata;
    logic [31:0] fp_ram_rdata;

    logic [31:0] mem [0:63];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign fp_ram_rdata = 32'h0000_0000;
    assign ram_rdata    = (ram_addr[15:12] == 4'h1) ? KBD_WORD : mem[ram_addr[7:2]];

    // RAM model: preload during reset, otherwise commit writes on the edge.
    always @(posedge clk) begin
        if (preload) begin
            mem[4]  <= 32'hDEAD_BEEF;
            mem[8]  <= 32'h0000_0000;
            mem[12] <= 32'hCAFE_F00D;
        end else if (ram_cs && ram_we) begin
            mem[ram_addr[7:2]] <= ram_wdata;
        end
    end

    dmem_arbiter #(.IO_REGION(4'h1), .RR_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata),
        .ram_cs(ram_cs), .ram_r(ram_r), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
    );

    dmem_arbiter #(.IO_REGION(4'h1), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(fp_m0_ack), .m0_rdata(fp_m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(fp_m1_ack), .m1_rdata(fp_m1_rdata),
        .ram_cs(fp_ram_cs), .ram_r(fp_ram_r), .ram_we(fp_ram_we),
        .ram_addr(fp_ram_addr), .ram_wdata(fp_ram_wdata), .ram_rdata(fp_ram_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; preload = 1'b1;
        m0_req = 1'b0; m0_we = 1'b0; m0_addr = 32'h0; m0_wdata = 32'h0;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = 32'h0; m1_wdata = 32'h0;
        tick(); tick();
        preload = 1'b0;
        total++;
        if ({m0_ack, m1_ack} !== 2'b00) begin
            bad++; $display("FAIL reset_acks: got %b want 00", {m0_ack, m1_ack});
        end
        total++;
        if ({ram_cs, ram_r, ram_we} !== 3'b000) begin
            bad++; $display("FAIL reset_ram_ctl: got %b want 000", {ram_cs, ram_r, ram_we});
        end
        total++;
        if ((ram_addr | ram_wdata) !== 32'h0) begin
            bad++; $display("FAIL reset_ram_bus: got addr %h wdata %h want 0", ram_addr, ram_wdata);
        end
        total++;
        if ((m0_rdata | m1_rdata) !== 32'h0) begin
            bad++; $display("FAIL reset_rdata: got %h %h want 0", m0_rdata, m1_rdata);
        end
        total++;
        if ({fp_m0_ack, fp_m1_ack, fp_ram_cs, fp_ram_r, fp_ram_we} !== 5'b00000) begin
            bad++; $display("FAIL reset_fp_ctl: got %b want 00000",
                            {fp_m0_ack, fp_m1_ack, fp_ram_cs, fp_ram_r, fp_ram_we});
        end
        total++;
        if ((fp_m0_rdata | fp_m1_rdata | fp_ram_addr | fp_ram_wdata) !== 32'h0) begin
            bad++; $display("FAIL reset_fp_bus: got nonzero data/address want 0");
        end
        rst_n = 1'b1;
        tick();
        total++;
        if (ram_cs !== 1'b0) begin
            bad++; $display("FAIL idle_no_req: ram_cs got %b want 0", ram_cs);
        end
    endtask

    task automatic test_read_m0();
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
        tick();
        total++;
        if ({ram_cs, ram_r, ram_we} !== 3'b110 || ram_addr !== 32'h10 || m0_ack !== 1'b0) begin
            bad++; $display("FAIL read_access: ctl %b addr %h ack %b want 110 00000010 0",
                            {ram_cs, ram_r, ram_we}, ram_addr, m0_ack);
        end
        tick();
        total++;
        if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL read_done: acks %b rdata %h want 10 deadbeef", {m0_ack, m1_ack}, m0_rdata);
        end
        total++;
        if ({ram_cs, ram_r, ram_we} !== 3'b000) begin
            bad++; $display("FAIL read_done_ctl: got %b want 000", {ram_cs, ram_r, ram_we});
        end
        tick();
        total++;
        if (m0_ack !== 1'b0 || m0_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL read_hold: ack %b rdata %h want 0 deadbeef", m0_ack, m0_rdata);
        end
        m0_req = 1'b0;
    endtask

    task automatic test_write_read_m1();
        int we_cnt = 0;
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h0000_0020; m1_wdata = 32'h1234_5678;
        tick();
        if (ram_we) we_cnt++;
        total++;
        if (ram_addr !== 32'h20 || ram_wdata !== 32'h1234_5678 || ram_r !== 1'b0) begin
            bad++; $display("FAIL write_access: addr %h wdata %h r %b want 00000020 12345678 0",
                            ram_addr, ram_wdata, ram_r);
        end
        tick();
        if (ram_we) we_cnt++;
        total++;
        if ({m0_ack, m1_ack} !== 2'b01 || m1_rdata !== 32'h0) begin
            bad++; $display("FAIL write_ack: acks %b rdata %h want 01 00000000", {m0_ack, m1_ack}, m1_rdata);
        end
        tick();
        if (ram_we) we_cnt++;
        m1_we = 1'b0;
        tick();
        if (ram_we) we_cnt++;
        tick();
        if (ram_we) we_cnt++;
        total++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h1234_5678) begin
            bad++; $display("FAIL readback: ack %b rdata %h want 1 12345678", m1_ack, m1_rdata);
        end
        total++;
        if (m0_rdata !== 32'hDEAD_BEEF || m0_ack !== 1'b0) begin
            bad++; $display("FAIL idle_master_hold: ack %b rdata %h want 0 deadbeef", m0_ack, m0_rdata);
        end
        total++;
        if (we_cnt != 1) begin
            bad++; $display("FAIL we_pulse: ram_we cycles %0d want 1", we_cnt);
        end
        tick();
        m1_req = 1'b0;
    endtask

    task automatic test_io_write();
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_1004; m0_wdata = 32'hFFFF_FFFF;
        tick();
        total++;
        if ({ram_cs, ram_r, ram_we} !== 3'b100) begin
            bad++; $display("FAIL io_suppress: ctl %b want 100", {ram_cs, ram_r, ram_we});
        end
        tick();
        total++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'h0) begin
            bad++; $display("FAIL io_ack: ack %b rdata %h want 1 00000000", m0_ack, m0_rdata);
        end
        tick();
        m0_we = 1'b0;
        tick();
        tick();
        total++;
        if (m0_ack !== 1'b1 || m0_rdata !== KBD_WORD) begin
            bad++; $display("FAIL io_read: ack %b rdata %h want 1 %h", m0_ack, m0_rdata, KBD_WORD);
        end
        tick();
        m0_req = 1'b0;
    endtask

    task automatic test_addr_change();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0020;
        tick();
        m1_addr = 32'h0000_0030;
        #1;
        total++;
        if (ram_addr !== 32'h20) begin
            bad++; $display("FAIL addr_latched: ram_addr %h want 00000020", ram_addr);
        end
        tick();
        total++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h1234_5678) begin
            bad++; $display("FAIL addr_latched_data: ack %b rdata %h want 1 12345678", m1_ack, m1_rdata);
        end
        tick();
        m1_req = 1'b0; m1_addr = 32'h0000_0020;
    endtask

    task automatic test_back_to_back();
        logic [1:0] exp_rr;
        logic [1:0] exp_fp;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0020;
        for (int k = 1; k <= 12; k++) begin
            tick();
            exp_rr = 2'b00;
            exp_fp = 2'b00;
            if ((k % 3) == 2) begin
                exp_fp = 2'b10;
                if (((k / 3) % 2) == 0) begin
                    exp_rr = 2'b10;
                end else begin
                    exp_rr = 2'b01;
                end
            end
            total++;
            if ({m0_ack, m1_ack} !== exp_rr) begin
                bad++; $display("FAIL rr_acks k=%0d: got %b want %b", k, {m0_ack, m1_ack}, exp_rr);
            end
            total++;
            if ({fp_m0_ack, fp_m1_ack} !== exp_fp) begin
                bad++; $display("FAIL fp_acks k=%0d: got %b want %b", k, {fp_m0_ack, fp_m1_ack}, exp_fp);
            end
        end
        total++;
        if (m0_rdata !== 32'hDEAD_BEEF || m1_rdata !== 32'h1234_5678) begin
            bad++; $display("FAIL rr_rdata: got %h %h want deadbeef 12345678", m0_rdata, m1_rdata);
        end
        m0_req = 1'b0; m1_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_abort();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0020;
        tick();
        total++;
        if (ram_cs !== 1'b1) begin
            bad++; $display("FAIL abort_access: ram_cs %b want 1", ram_cs);
        end
        rst_n = 1'b0; m1_req = 1'b0;
        tick();
        total++;
        if (m1_ack !== 1'b0 || {ram_cs, ram_r, ram_we} !== 3'b000) begin
            bad++; $display("FAIL abort_reset: ack %b ctl %b want 0 000", m1_ack, {ram_cs, ram_r, ram_we});
        end
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0010;
        tick();
        total++;
        if ({ram_cs, ram_r, ram_we} !== 3'b110 || m1_ack !== 1'b0) begin
            bad++; $display("FAIL abort_fresh_access: ctl %b ack1 %b want 110 0", {ram_cs, ram_r, ram_we}, m1_ack);
        end
        tick();
        total++;
        if ({m0_ack, m1_ack} !== 2'b10 || m0_rdata !== 32'hDEAD_BEEF) begin
            bad++; $display("FAIL abort_fresh_ack: acks %b rdata %h want 10 deadbeef", {m0_ack, m1_ack}, m0_rdata);
        end
        tick();
        m0_req = 1'b0;
    endtask

    initial begin
        test_reset();
        test_read_m0();
        test_write_read_m1();
        test_io_write();
        test_addr_change();
        test_back_to_back();
        test_reset_abort();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
